voice_sequencer: RTL and testbench

Time-multiplexes the single wavetable ROM read port across NUM_VOICES phase accumulators.
- Holds per-voice frequency/gate config written by the MIDI/SPI front end.
- On each sample tick, sequences the ROM address for every voice in turn, advances the phase accumulators and sums the returned samples into one mixed sample for the R2R output stage.

---
 rtl/voice_sequencer.sv | 132 +++++++++++++
 tb/tb_voice_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sequencer.sv
// voice_sequencer: time-multiplexes one wavetable ROM read port across NUM_VOICES
// phase accumulators and mixes the returned samples into one averaged output.
//   clk          system clock
//   nreset       asynchronous active-low reset
//   cfg_valid    config write request
//   cfg_ready    high only while idle; write accepted when cfg_valid && cfg_ready
//   cfg_voice    target voice of a config write
//   cfg_freq     phase increment per sample tick
//   cfg_gate     1 = note on, 0 = note off
//   rom_addr     registered ROM address (top ADDR_W bits of the voice phase)
//   rom_data     ROM sample, valid the cycle after its address is presented
//   mix_out      average of all voice samples, midscale when silent
//   sample_valid one-cycle pulse when mix_out updates
//   active_mask  current gate bit per voice
module voice_sequencer #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 32,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 24,
    parameter int SAMPLE_DIV = 100
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_freq,
    input  logic                          cfg_gate,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_data,
    output logic [DATA_W-1:0]             mix_out,
    output logic                          sample_valid,
    output logic [NUM_VOICES-1:0]         active_mask
);
    localparam int SW    = $clog2(NUM_VOICES);
    localparam int TW    = $clog2(SAMPLE_DIV);
    localparam int ACC_W = DATA_W + SW;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PUBLISH} state_t;

    state_t              state;
    logic [TW-1:0]       tick_cnt;
    logic [SW-1:0]       slot;
    logic [SW-1:0]       next_slot;
    logic [PHASE_W-1:0]  phase [NUM_VOICES];
    logic [PHASE_W-1:0]  freq  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate;
    logic [ACC_W-1:0]    acc;
    logic                pipe_valid;
    logic                pipe_gate;
    logic                tick;
    logic                accept;

    assign tick        = tick_cnt == TW'(SAMPLE_DIV - 1);
    assign cfg_ready   = state == IDLE;
    assign accept      = cfg_valid && cfg_ready;
    assign active_mask = gate;
    assign next_slot   = slot + SW'(1);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            tick_cnt <= '0;
        else
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    // Config writes only land in IDLE, so they never collide with the
    // per-slot phase update done in FETCH.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                freq[i]  <= '0;
            end
            gate <= '0;
        end else if (accept) begin
            freq[cfg_voice] <= cfg_freq;
            gate[cfg_voice] <= cfg_gate;
            // a fresh note always starts from phase 0
            if (cfg_gate && !gate[cfg_voice])
                phase[cfg_voice] <= '0;
        end else if (state == FETCH) begin
            phase[slot] <= gate[slot] ? phase[slot] + freq[slot] : '0;
        end
    end

    // The address for a slot is its phase before that slot's update, so it is
    // issued one cycle ahead (slot 0 on the tick edge). Each ROM word is then
    // accumulated in the FETCH cycle after its address, tagged by pipe_valid.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            slot         <= '0;
            rom_addr     <= '0;
            acc          <= '0;
            pipe_valid   <= 1'b0;
            pipe_gate    <= 1'b0;
            mix_out      <= MID;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            pipe_valid   <= state == FETCH;
            pipe_gate    <= gate[slot];
            if (pipe_valid)
                acc <= acc + ACC_W'(pipe_gate ? rom_data : MID);
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= FETCH;
                        slot     <= '0;
                        acc      <= '0;
                        rom_addr <= phase[0][PHASE_W-1 -: ADDR_W];
                    end
                end
                FETCH: begin
                    slot <= next_slot;
                    if (slot == SW'(NUM_VOICES - 1))
                        state <= DRAIN;
                    else
                        rom_addr <= phase[next_slot][PHASE_W-1 -: ADDR_W];
                end
                DRAIN: state <= PUBLISH;
                PUBLISH: begin
                    mix_out      <= acc[ACC_W-1:SW];
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer: table-driven and directed checks of voice_sequencer with
// SAMPLE_DIV=16 and a ROM that returns its own address one cycle later.
module tb_voice_sequencer;
    localparam int NV  = 8;
    localparam int PW  = 32;
    localparam int AW  = 12;
    localparam int DW  = 24;
    localparam int DIV = 16;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [2:0]    cfg_voice = '0;
    logic [PW-1:0] cfg_freq = '0;
    logic          cfg_gate = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] mix_out;
    logic          sample_valid;
    logic [NV-1:0] active_mask;

    int            cyc;
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] addr_seq [NV];
    logic [NV-1:0] exp_mask = '0;

    typedef struct {
        logic          wr;
        logic [2:0]    v;
        logic [31:0]   f;
        logic          g;
        logic [11:0]   a0;
        logic [11:0]   a3;
        logic [23:0]   mix;
        logic [7:0]    mask;
    } vec_t;

    vec_t vecs [14];

    voice_sequencer #(
        .NUM_VOICES(NV), .PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW), .SAMPLE_DIV(DIV)
    ) dut (
        .clk(clk), .nreset(nreset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_voice(cfg_voice), .cfg_freq(cfg_freq), .cfg_gate(cfg_gate),
        .rom_addr(rom_addr), .rom_data(rom_data), .mix_out(mix_out),
        .sample_valid(sample_valid), .active_mask(active_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= {{(DW-AW){1'b0}}, rom_addr};

    // cyc mirrors the sample-tick counter: tick when cyc%16==15, slot k address
    // visible when cyc%16==k, sample_valid when cyc%16==10.
    always @(posedge clk or negedge nreset)
        if (!nreset) cyc <= 0;
        else cyc <= cyc + 1;

    always @(negedge clk)
        if (nreset && (cyc % DIV) < NV) addr_seq[cyc % DIV] <= rom_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_sample();
        int n = 0;
        @(negedge clk);
        while (!sample_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("sample_seen", 32'(sample_valid), 1);
        check("sample_latency", cyc % DIV, 10);
    endtask

    task automatic goto(input int c);
        int n = 0;
        while (cyc != c && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("goto_cycle", cyc, c);
    endtask

    task automatic write_cfg(input logic [2:0] v, input logic [31:0] f, input logic g);
        int n = 0;
        while (!cfg_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("cfg_ready_idle", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_voice = v;
        cfg_freq  = f;
        cfg_gate  = g;
        check("mask_before_accept", 32'(active_mask), 32'(exp_mask));
        exp_mask[v] = g;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("mask_after_accept", 32'(active_mask), 32'(exp_mask));
    endtask

    task automatic do_reset();
        nreset    = 1'b0;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_mix_out", 32'(mix_out), 32'h800000);
        check("rst_sample_valid", 32'(sample_valid), 0);
        check("rst_active_mask", 32'(active_mask), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        nreset   = 1'b1;
        exp_mask = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        //            wr    v     freq          g     a0       a3       mix          mask
        vecs[0]  = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'h000, 12'h000, 24'h800000, 8'h00};
        vecs[1]  = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'h000, 12'h000, 24'h800000, 8'h00};
        vecs[2]  = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'h000, 12'h000, 24'h800000, 8'h00};
        vecs[3]  = '{1'b1, 3'd0, 32'h00100000, 1'b1, 12'h000, 12'h000, 24'h700000, 8'h01};
        vecs[4]  = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'h001, 12'h000, 24'h700000, 8'h01};
        vecs[5]  = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'h002, 12'h000, 24'h700000, 8'h01};
        vecs[6]  = '{1'b1, 3'd0, 32'h00100000, 1'b0, 12'h003, 12'h000, 24'h800000, 8'h00};
        vecs[7]  = '{1'b1, 3'd0, 32'hFFF00000, 1'b1, 12'h000, 12'h000, 24'h700000, 8'h01};
        vecs[8]  = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'hFFF, 12'h000, 24'h7001FF, 8'h01};
        vecs[9]  = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'hFFE, 12'h000, 24'h7001FF, 8'h01};
        vecs[10] = '{1'b1, 3'd3, 32'h40000000, 1'b1, 12'hFFD, 12'h000, 24'h6001FF, 8'h09};
        vecs[11] = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'hFFC, 12'h400, 24'h60027F, 8'h09};
        vecs[12] = '{1'b1, 3'd3, 32'h40000000, 1'b0, 12'hFFB, 12'h800, 24'h7001FF, 8'h01};
        vecs[13] = '{1'b0, 3'd0, 32'h00000000, 1'b0, 12'hFFA, 12'h000, 24'h7001FF, 8'h01};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) write_cfg(vecs[i].v, vecs[i].f, vecs[i].g);
            wait_sample();
            check($sformatf("vec%0d_addr_slot0", i), 32'(addr_seq[0]), 32'(vecs[i].a0));
            check($sformatf("vec%0d_addr_slot3", i), 32'(addr_seq[3]), 32'(vecs[i].a3));
            check($sformatf("vec%0d_mix_out", i), 32'(mix_out), 32'(vecs[i].mix));
            check($sformatf("vec%0d_active_mask", i), 32'(active_mask), 32'(vecs[i].mask));
        end

        // write held during FETCH waits for IDLE; write in a tick cycle is used at once
        do_reset();
        goto(16);
        check("ready_low_in_fetch", 32'(cfg_ready), 0);
        cfg_valid = 1'b1;
        cfg_voice = 3'd5;
        cfg_freq  = 32'h10000000;
        cfg_gate  = 1'b1;
        n = 0;
        while (!cfg_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_rise_cycle", cyc, 26);
        check("ready_with_sample", 32'(sample_valid), 1);
        check("held_mask_before", 32'(active_mask), 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        exp_mask  = 8'h20;
        check("held_mask_after", 32'(active_mask), 32'h20);
        wait_sample();
        check("held_r1_addr5", 32'(addr_seq[5]), 0);
        check("held_r1_mix", 32'(mix_out), 32'h700000);
        wait_sample();
        check("held_r2_addr5", 32'(addr_seq[5]), 32'h100);
        check("held_r2_mix", 32'(mix_out), 32'h700020);
        goto(63);
        write_cfg(3'd2, 32'h20000000, 1'b1);
        wait_sample();
        check("tickwr_addr2", 32'(addr_seq[2]), 0);
        check("tickwr_addr5", 32'(addr_seq[5]), 32'h200);
        check("tickwr_mix", 32'(mix_out), 32'h600040);
        check("tickwr_mask", 32'(active_mask), 32'h24);

        // reset asserted during FETCH slot 4 aborts the sequence
        do_reset();
        write_cfg(3'd4, 32'h00500000, 1'b1);
        goto(36);
        check("pre_abort_addr", 32'(rom_addr), 5);
        check("pre_abort_mix", 32'(mix_out), 32'h700000);
        nreset = 1'b0;
        #1;
        check("abort_rom_addr", 32'(rom_addr), 0);
        check("abort_mix_out", 32'(mix_out), 32'h800000);
        check("abort_mask", 32'(active_mask), 0);
        check("abort_sample_valid", 32'(sample_valid), 0);
        check("abort_cfg_ready", 32'(cfg_ready), 1);
        do_reset();
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            pulses += int'(sample_valid);
        end
        check("no_pulse_after_abort", pulses, 0);
        wait_sample();
        check("post_abort_mix", 32'(mix_out), 32'h800000);
        check("post_abort_addr4", 32'(addr_seq[4]), 0);
        check("post_abort_mask", 32'(active_mask), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
